// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared definitions for the 3x3 keypad scanner: FSM state
//                encoding, the "no key" code, default timing parameters and
//                the row/column to key-code mapping.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } scan_state_t;

    localparam logic [3:0] KEY_NONE             = 4'd0;
    localparam int         SCAN_DIV_DEFAULT     = 12000;
    localparam int         DEBOUNCE_CNT_DEFAULT = 8;

    // row_idx is zero-based (0..2), col is one-based (1..3); result is 1..9.
    function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                            input logic [1:0] col);
        return (4'(row_idx) * 4'd3) + 4'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Free-running divider counting 0..SCAN_DIV-1; tick is high
//                for the single cycle in which the count equals SCAN_DIV-1.
//  Ports       : hwclk - clock
//                rst   - synchronous active-high reset
//                tick  - one-cycle row-dwell strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen
    import lock_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic hwclk,
    input  logic rst,
    output logic tick
);

    localparam int            CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == C_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 3x3 matrix keypad scanner with debounced press/release.
//                Rows are driven low one at a time; the columns are
//                synchronized and sampled once per row dwell (tick).
//  Ports       : hwclk                  - clock
//                rst                    - synchronous active-high reset
//                keypad_r1..r3 (out)    - active-low row drives
//                keypad_c1..c3 (in)     - pulled-up column senses
//                button[3:0]   (out)    - last accepted key code (1..9)
//                bstate        (out)    - high while a debounced key is held
//                key_strobe    (out)    - one-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import lock_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic       hwclk,
    input  logic       rst,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_strobe
);

    localparam int            DW         = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] C_DEB_DONE = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] C_DEB_ONE  = DW'(1);

    logic              w_tick;
    logic [2:0]        r_col_meta;
    logic [2:0]        r_col_sync;     // bit0 = c1
    scan_state_t       r_state;
    logic [1:0]        r_row;          // zero-based active row index
    logic [2:0]        r_rows_n;       // bit0 = r1, one bit low
    logic [1:0]        r_cand_col;     // one-based candidate column
    logic [DW-1:0]     r_cnt;
    logic [3:0]        r_button;
    logic              r_bstate;
    logic              r_strobe;

    logic [1:0]        w_low_col;      // lowest low column, 0 = none
    logic              w_cand_high;
    logic [DW-1:0]     w_cnt_next;
    logic [1:0]        w_row_next;
    logic [2:0]        w_rows_n_next;
    logic [3:0]        w_code;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .hwclk (hwclk),
        .rst   (rst),
        .tick  (w_tick)
    );

    always_comb begin
        w_low_col = 2'd0;
        if (!r_col_sync[0]) begin
            w_low_col = 2'd1;
        end else if (!r_col_sync[1]) begin
            w_low_col = 2'd2;
        end else if (!r_col_sync[2]) begin
            w_low_col = 2'd3;
        end
    end

    always_comb begin
        w_cand_high = 1'b1;
        case (r_cand_col)
            2'd1:    w_cand_high = r_col_sync[0];
            2'd2:    w_cand_high = r_col_sync[1];
            2'd3:    w_cand_high = r_col_sync[2];
            default: w_cand_high = 1'b1;
        endcase
    end

    assign w_cnt_next    = r_cnt + 1'b1;
    assign w_row_next    = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
    assign w_rows_n_next = {r_rows_n[1:0], r_rows_n[2]};
    // Valid whenever a press is being accepted: in DEB_PRESS acceptance
    // requires w_low_col to equal the candidate column.
    assign w_code        = key_code(r_row, w_low_col);

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_col_meta <= 3'b000;
            r_col_sync <= 3'b000;
            r_state    <= SCAN;
            r_row      <= 2'd0;
            r_rows_n   <= 3'b110;
            r_cand_col <= 2'd0;
            r_cnt      <= '0;
            r_button   <= KEY_NONE;
            r_bstate   <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_col_meta <= {keypad_c3, keypad_c2, keypad_c1};
            r_col_sync <= r_col_meta;
            r_strobe   <= 1'b0;

            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_low_col != 2'd0) begin
                            r_cand_col <= w_low_col;
                            if (DEBOUNCE_CNT <= 1) begin
                                r_button <= w_code;
                                r_bstate <= 1'b1;
                                r_strobe <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= PRESSED;
                            end else begin
                                r_cnt   <= C_DEB_ONE;
                                r_state <= DEB_PRESS;
                            end
                        end else begin
                            r_row    <= w_row_next;
                            r_rows_n <= w_rows_n_next;
                        end
                    end

                    DEB_PRESS: begin
                        if (w_low_col == r_cand_col) begin
                            if (w_cnt_next == C_DEB_DONE) begin
                                r_button <= w_code;
                                r_bstate <= 1'b1;
                                r_strobe <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= PRESSED;
                            end else begin
                                r_cnt <= w_cnt_next;
                            end
                        end else begin
                            r_cnt    <= '0;
                            r_state  <= SCAN;
                            r_row    <= w_row_next;
                            r_rows_n <= w_rows_n_next;
                        end
                    end

                    PRESSED: begin
                        if (w_cand_high) begin
                            if (DEBOUNCE_CNT <= 1) begin
                                r_bstate <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= SCAN;
                                r_row    <= w_row_next;
                                r_rows_n <= w_rows_n_next;
                            end else begin
                                r_cnt   <= C_DEB_ONE;
                                r_state <= DEB_RELEASE;
                            end
                        end
                    end

                    DEB_RELEASE: begin
                        if (w_cand_high) begin
                            if (w_cnt_next == C_DEB_DONE) begin
                                r_bstate <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= SCAN;
                                r_row    <= w_row_next;
                                r_rows_n <= w_rows_n_next;
                            end else begin
                                r_cnt <= w_cnt_next;
                            end
                        end else begin
                            // Release bounce: back to held, no new strobe.
                            r_cnt   <= '0;
                            r_state <= PRESSED;
                        end
                    end

                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign keypad_r1  = r_rows_n[0];
    assign keypad_r2  = r_rows_n[1];
    assign keypad_r3  = r_rows_n[2];
    assign button     = r_button;
    assign bstate     = r_bstate;
    assign key_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//                DEBOUNCE_CNT=3) with a behavioural 3x3 key matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       hwclk;
    logic       rst;
    logic       keypad_r1, keypad_r2, keypad_r3;
    logic [2:0] col_n;
    logic [3:0] button;
    logic       bstate;
    logic       key_strobe;
    logic [9:1] keys;

    int n_cmp;
    int n_fail;
    int n_strobes;
    int exp_q[$];

    typedef struct {
        logic [9:1] keys;
        int         hold;
        int         exp_code;
    } vec_t;

    vec_t vecs[7];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .hwclk      (hwclk),
        .rst        (rst),
        .keypad_r1  (keypad_r1),
        .keypad_r2  (keypad_r2),
        .keypad_r3  (keypad_r3),
        .keypad_c1  (col_n[0]),
        .keypad_c2  (col_n[1]),
        .keypad_c3  (col_n[2]),
        .button     (button),
        .bstate     (bstate),
        .key_strobe (key_strobe)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // Key matrix: a closed key shorts its column to its row.
    logic [2:0] rows_low;
    assign rows_low = ~{keypad_r3, keypad_r2, keypad_r1};

    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (rows_low[r] && keys[3*r + c + 1]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge hwclk) begin
        if (key_strobe) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe with button=%0d, expected none", button);
            end else begin
                check("strobe_button", int'(button), exp_q.pop_front());
            end
        end
    end

    function automatic logic [9:1] km(input int k);
        logic [9:1] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    function automatic int rows_now();
        return int'({keypad_r1, keypad_r2, keypad_r3});
    endfunction

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_bstate(input logic val, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (bstate == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s0;
        bit seen;
        n_cmp     = 0;
        n_fail    = 0;
        n_strobes = 0;
        keys      = '0;
        rst       = 1'b1;

        vecs[0] = '{km(5),          80, 5};
        vecs[1] = '{km(7) | km(9),  20, 7};
        vecs[2] = '{km(1),          20, 1};
        vecs[3] = '{km(9),          20, 9};
        vecs[4] = '{km(4) | km(6),  20, 4};
        vecs[5] = '{km(2) | km(3),  20, 2};
        vecs[6] = '{km(8),          20, 8};

        // Reset values and free scanning.
        step();
        step();
        check("rst_rows",   rows_now(), 3'b011);
        check("rst_button", int'(button), 0);
        check("rst_bstate", int'(bstate), 0);
        check("rst_strobe", int'(key_strobe), 0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3)  check("scan_r1_dwell", rows_now(), 3'b011);
            if (i == 4)  check("scan_r2",       rows_now(), 3'b101);
            if (i == 8)  check("scan_r3",       rows_now(), 3'b110);
            if (i == 12) check("scan_wrap_r1",  rows_now(), 3'b011);
        end

        // Exact press and release latency on key 1.
        keys = km(1);
        exp_q.push_back(1);
        reset_dut();
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i == 11) check("lat_pre_strobe", int'(key_strobe), 0);
            if (i == 12) begin
                check("lat_strobe", int'(key_strobe), 1);
                check("lat_bstate", int'(bstate), 1);
                check("lat_button", int'(button), 1);
                keys = '0;
            end
            if (i == 13) check("strobe_one_cycle", int'(key_strobe), 0);
            if (i == 23) check("rel_hold_bstate", int'(bstate), 1);
            if (i == 24) begin
                check("rel_bstate",  int'(bstate), 0);
                check("rel_button",  int'(button), 1);
                check("rel_row_adv", rows_now(), 3'b101);
            end
        end

        // Press bounce: two low samples then open.
        keys = km(1);
        s0 = n_strobes;
        reset_dut();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 8) keys = '0;
            if (i == 12) begin
                check("bounce_bstate", int'(bstate), 0);
                check("bounce_row_r2", rows_now(), 3'b101);
            end
            if (i == 16) check("bounce_row_r3", rows_now(), 3'b110);
        end
        check("bounce_no_strobe", n_strobes - s0, 0);

        // Release bounce: open for two samples, then closed again.
        keys = km(1);
        exp_q.push_back(1);
        s0 = n_strobes;
        reset_dut();
        for (int i = 1; i <= 44; i++) begin
            step();
            if (i == 12) keys = '0;
            if (i == 20) keys = km(1);
            if (i == 24) check("relb_bstate_24", int'(bstate), 1);
            if (i == 44) check("relb_bstate_44", int'(bstate), 1);
        end
        check("relb_one_strobe", n_strobes - s0, 1);
        keys = '0;
        wait_bstate(1'b0, 100, ok);
        check("relb_released", int'(ok), 1);

        // Reset while a key is held.
        keys = km(1);
        exp_q.push_back(1);
        reset_dut();
        for (int i = 1; i <= 14; i++) step();
        check("mid_pre_bstate", int'(bstate), 1);
        rst = 1'b1;
        step();
        check("mid_rst_bstate", int'(bstate), 0);
        check("mid_rst_button", int'(button), 0);
        check("mid_rst_strobe", int'(key_strobe), 0);
        check("mid_rst_rows",   rows_now(), 3'b011);
        rst = 1'b0;
        exp_q.push_back(1);
        s0   = n_strobes;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (key_strobe && !seen) begin
                seen = 1'b1;
                check("mid_restrobe_cycle", i, 12);
            end
        end
        check("mid_restrobe_count", n_strobes - s0, 1);
        keys = '0;
        wait_bstate(1'b0, 100, ok);
        check("mid_released", int'(ok), 1);

        // Table of single / multi-key presses.
        for (int v = 0; v < 7; v++) begin
            s0   = n_strobes;
            keys = vecs[v].keys;
            exp_q.push_back(vecs[v].exp_code);
            wait_bstate(1'b1, 100, ok);
            check("vec_press_seen", int'(ok), 1);
            check("vec_button", int'(button), vecs[v].exp_code);
            repeat (vecs[v].hold) step();
            check("vec_held", int'(bstate), 1);
            keys = '0;
            wait_bstate(1'b0, 100, ok);
            check("vec_release_seen", int'(ok), 1);
            repeat (10) step();
            check("vec_button_stable", int'(button), vecs[v].exp_code);
            check("vec_strobes", n_strobes - s0, 1);
        end

        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
